ifu_miss_ctrl: RTL and testbench

Miss handler and memory-request sequencer for the IFU instruction cache. It accepts one line miss at a time from the cache and issues a tag request to instruction memory with a valid/ready handshake. It waits for the matching response, retrying on timeout, then delivers a one-cycle fill (tag plus line) back to the cache. An optional next-line prefetch reuses the same memory port when the controller is otherwise idle.

---
 rtl/ifu_miss_ctrl_if.sv | 36 +++
 rtl/ifu_miss_ctrl.sv | 144 ++++++++++++++
 tb/tb_ifu_miss_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_miss_ctrl_if.sv
// Miss/fill/memory-port bundle between the I-cache miss controller (master) and the cache plus memory (slave).
// Widths must match the parameters of the ifu_miss_ctrl instance that uses the bundle.
interface ifu_miss_ctrl_if #(
    parameter int TAG_W  = 28,
    parameter int LINE_W = 128
);
    logic              miss_valid;
    logic [TAG_W-1:0]  miss_tag;
    logic              miss_ready;
    logic              flush;
    logic              mem_req_valid;
    logic [TAG_W-1:0]  mem_req_tag;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [TAG_W-1:0]  mem_rsp_tag;
    logic [LINE_W-1:0] mem_rsp_line;
    logic              fill_valid;
    logic [TAG_W-1:0]  fill_tag;
    logic [LINE_W-1:0] fill_line;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  miss_valid, miss_tag, flush, mem_req_ready,
               mem_rsp_valid, mem_rsp_tag, mem_rsp_line,
        output miss_ready, mem_req_valid, mem_req_tag,
               fill_valid, fill_tag, fill_line, busy, timeout_err
    );

    modport slave (
        output miss_valid, miss_tag, flush, mem_req_ready,
               mem_rsp_valid, mem_rsp_tag, mem_rsp_line,
        input  miss_ready, mem_req_valid, mem_req_tag,
               fill_valid, fill_tag, fill_line, busy, timeout_err
    );
endinterface

// File: rtl/ifu_miss_ctrl.sv
// I-cache miss sequencer: miss accept -> tag request -> wait/retry on timeout -> one-cycle fill; 3 cycles miss-to-fill minimum.
// Request held until mem_req_ready; responses have no backpressure. IFU_MISS_PREFETCH_EN adds idle-time next-line prefetch.
module ifu_miss_ctrl #(
    parameter int TAG_W   = 28,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic Clock,
    input  logic Rst,
    ifu_miss_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
`ifdef IFU_MISS_PREFETCH_EN
        ,
        S_PF_REQ,
        S_PF_WAIT,
        S_PF_FILL
`endif
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [TAG_W-1:0]  cur_tag;
    logic [TAG_W-1:0]  tag_nxt;
    logic [7:0]        tmo_cnt;
    logic              rsp_hit;
    logic              tmo_hit;
    logic              in_wait;
    logic              nxt_wait;
    logic              nxt_req;
    logic              nxt_fill;
    logic              tmo_evt;

    logic              miss_ready_q;
    logic              req_valid_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic              fill_valid_q;
    logic [TAG_W-1:0]  fill_tag_q;
    logic [LINE_W-1:0] fill_line_q;
    logic              busy_q;
    logic              timeout_err_q;

    assign rsp_hit = bus.mem_rsp_valid && (bus.mem_rsp_tag == cur_tag);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

`ifdef IFU_MISS_PREFETCH_EN
    assign in_wait  = (state == S_WAIT) || (state == S_PF_WAIT);
    assign nxt_wait = (state_nxt == S_WAIT) || (state_nxt == S_PF_WAIT);
    assign nxt_req  = (state_nxt == S_REQ) || (state_nxt == S_PF_REQ);
    assign nxt_fill = (state_nxt == S_FILL) || (state_nxt == S_PF_FILL);
`else
    assign in_wait  = (state == S_WAIT);
    assign nxt_wait = (state_nxt == S_WAIT);
    assign nxt_req  = (state_nxt == S_REQ);
    assign nxt_fill = (state_nxt == S_FILL);
`endif

    // A matching response in the final wait cycle beats the timeout; flush suppresses both.
    assign tmo_evt = in_wait && tmo_hit && !rsp_hit && !bus.flush;

    always_comb begin
        state_nxt = state;
        tag_nxt   = cur_tag;
        case (state)
            S_IDLE: begin
                if (bus.miss_valid) begin
                    state_nxt = S_REQ;
                    tag_nxt   = bus.miss_tag;
                end
            end
            S_REQ:  if (bus.mem_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (rsp_hit)      state_nxt = S_FILL;
                else if (tmo_hit) state_nxt = S_REQ;
            end
`ifdef IFU_MISS_PREFETCH_EN
            S_FILL: begin
                state_nxt = S_PF_REQ;
                tag_nxt   = cur_tag + {{(TAG_W-1){1'b0}}, 1'b1};
            end
            // An incoming miss only cancels a prefetch the memory has not yet taken.
            S_PF_REQ: begin
                if (bus.mem_req_ready)   state_nxt = S_PF_WAIT;
                else if (bus.miss_valid) state_nxt = S_IDLE;
            end
            S_PF_WAIT: begin
                if (rsp_hit)      state_nxt = S_PF_FILL;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_PF_FILL: state_nxt = S_IDLE;
`else
            S_FILL: state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // Outputs are registered from the next-state decode so they track the state with no input-to-output path.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state         <= S_IDLE;
            cur_tag       <= '0;
            tmo_cnt       <= '0;
            miss_ready_q  <= 1'b1;
            req_valid_q   <= 1'b0;
            req_tag_q     <= '0;
            fill_valid_q  <= 1'b0;
            fill_tag_q    <= '0;
            fill_line_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            cur_tag       <= tag_nxt;
            tmo_cnt       <= (in_wait && nxt_wait) ? tmo_cnt + 8'd1 : 8'd0;
            miss_ready_q  <= (state_nxt == S_IDLE);
            busy_q        <= (state_nxt != S_IDLE);
            req_valid_q   <= nxt_req;
            req_tag_q     <= nxt_req ? tag_nxt : '0;
            fill_valid_q  <= nxt_fill;
            fill_tag_q    <= nxt_fill ? cur_tag : '0;
            fill_line_q   <= nxt_fill ? bus.mem_rsp_line : '0;
            timeout_err_q <= tmo_evt;
        end
    end

    assign bus.miss_ready    = miss_ready_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_tag   = req_tag_q;
    assign bus.fill_valid    = fill_valid_q;
    assign bus.fill_tag      = fill_tag_q;
    assign bus.fill_line     = fill_line_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_ifu_miss_ctrl.sv
// Directed bench for ifu_miss_ctrl with TIMEOUT=4; prefetch expectations follow IFU_MISS_PREFETCH_EN.
module tb_ifu_miss_ctrl;

    localparam int TAG_W  = 28;
    localparam int LINE_W = 128;

    logic Clock = 1'b0;
    logic Rst   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] LINE_5A = {16{8'h5A}};
    localparam logic [LINE_W-1:0] LINE_C3 = {16{8'hC3}};

    ifu_miss_ctrl_if #(.TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

    ifu_miss_ctrl #(.TAG_W(TAG_W), .LINE_W(LINE_W), .TIMEOUT(4)) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus.master)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  LINE_W'(bus.busy), 0);
        chk({tag, "_mrdy"},  LINE_W'(bus.miss_ready), 1);
        chk({tag, "_reqv"},  LINE_W'(bus.mem_req_valid), 0);
        chk({tag, "_fillv"}, LINE_W'(bus.fill_valid), 0);
    endtask

    initial begin
        bus.miss_valid    = 1'b0;
        bus.miss_tag      = '0;
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_tag   = '0;
        bus.mem_rsp_line  = '0;
        repeat (2) @(posedge Clock);
        #1 Rst = 1'b0;

        // Reset state
        chk_idle("rst");
        chk("rst_tmo",   LINE_W'(bus.timeout_err), 0);
        chk("rst_line",  bus.fill_line, 0);
        chk("rst_ftag",  LINE_W'(bus.fill_tag), 0);

        // Basic miss 0x123, minimum latency
        bus.miss_valid = 1'b1; bus.miss_tag = 28'h123; bus.mem_req_ready = 1'b1;
        tick();
        chk("b_reqv",  LINE_W'(bus.mem_req_valid), 1);
        chk("b_reqt",  LINE_W'(bus.mem_req_tag), 28'h123);
        chk("b_mrdy",  LINE_W'(bus.miss_ready), 0);
        chk("b_busy",  LINE_W'(bus.busy), 1);
        bus.miss_valid = 1'b0;
        tick();
        chk("b_wait_reqv", LINE_W'(bus.mem_req_valid), 0);
        chk("b_wait_fill", LINE_W'(bus.fill_valid), 0);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 28'h123; bus.mem_rsp_line = LINE_A5;
        tick();
        chk("b_fillv", LINE_W'(bus.fill_valid), 1);
        chk("b_fillt", LINE_W'(bus.fill_tag), 28'h123);
        chk("b_filll", bus.fill_line, LINE_A5);
        chk("b_fill_reqv", LINE_W'(bus.mem_req_valid), 0);
        bus.mem_rsp_valid = 1'b0;
        tick();
        chk("b_post_fillv", LINE_W'(bus.fill_valid), 0);
`ifdef IFU_MISS_PREFETCH_EN
        chk("pf_reqv", LINE_W'(bus.mem_req_valid), 1);
        chk("pf_reqt", LINE_W'(bus.mem_req_tag), 28'h124);
        tick();
        chk("pf_wait_reqv", LINE_W'(bus.mem_req_valid), 0);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 28'h124; bus.mem_rsp_line = LINE_5A;
        tick();
        chk("pf_fillv", LINE_W'(bus.fill_valid), 1);
        chk("pf_fillt", LINE_W'(bus.fill_tag), 28'h124);
        chk("pf_filll", bus.fill_line, LINE_5A);
        bus.mem_rsp_valid = 1'b0;
        tick();
`endif
        chk_idle("b_end");

        // Stale response and timeout retry
        bus.miss_valid = 1'b1; bus.miss_tag = 28'h123;
        tick();
        bus.miss_valid = 1'b0;
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 28'h999; bus.mem_rsp_line = LINE_C3;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("st_fillv", LINE_W'(bus.fill_valid), 0);
        chk("st_busy",  LINE_W'(bus.busy), 1);
        tick();
        tick();
        chk("to_early", LINE_W'(bus.timeout_err), 0);
        chk("to_w4_reqv", LINE_W'(bus.mem_req_valid), 0);
        tick();
        chk("to_pulse", LINE_W'(bus.timeout_err), 1);
        chk("to_reqv",  LINE_W'(bus.mem_req_valid), 1);
        chk("to_reqt",  LINE_W'(bus.mem_req_tag), 28'h123);

        // Backpressure on the retried request
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_reqv", LINE_W'(bus.mem_req_valid), 1);
            chk("bp_reqt", LINE_W'(bus.mem_req_tag), 28'h123);
            chk("bp_tmo",  LINE_W'(bus.timeout_err), 0);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        chk("bp_wait_reqv", LINE_W'(bus.mem_req_valid), 0);
        chk("bp_wait_busy", LINE_W'(bus.busy), 1);

        // Flush in WAIT, then a late matching response
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_idle("fl");
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 28'h123; bus.mem_rsp_line = LINE_A5;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk_idle("fl_late");

        // Matching response on the last wait cycle wins over timeout
        bus.miss_valid = 1'b1; bus.miss_tag = 28'h0AB;
        tick();
        bus.miss_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 28'h0AB; bus.mem_rsp_line = LINE_5A;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("race_fillv", LINE_W'(bus.fill_valid), 1);
        chk("race_fillt", LINE_W'(bus.fill_tag), 28'h0AB);
        chk("race_tmo",   LINE_W'(bus.timeout_err), 0);
        chk("race_reqv",  LINE_W'(bus.mem_req_valid), 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_idle("race_end");

        // Asynchronous reset mid-WAIT
        bus.miss_valid = 1'b1; bus.miss_tag = 28'h055;
        tick();
        bus.miss_valid = 1'b0;
        tick();
        chk("ar_busy_pre", LINE_W'(bus.busy), 1);
        Rst = 1'b1;
        #2;
        chk_idle("ar_async");
        Rst = 1'b0;
        tick();
        chk_idle("ar_next");
        chk("ar_line", bus.fill_line, 0);

        // Fill of the all-ones tag
        bus.miss_valid = 1'b1; bus.miss_tag = 28'hFFFFFFF;
        tick();
        chk("wr_reqt", LINE_W'(bus.mem_req_tag), 28'hFFFFFFF);
        bus.miss_valid = 1'b0;
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 28'hFFFFFFF; bus.mem_rsp_line = LINE_C3;
        tick();
        chk("wr_fillt", LINE_W'(bus.fill_tag), 28'hFFFFFFF);
        chk("wr_filll", bus.fill_line, LINE_C3);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        tick();
`ifdef IFU_MISS_PREFETCH_EN
        chk("wr_pf_reqv", LINE_W'(bus.mem_req_valid), 1);
        chk("wr_pf_reqt", LINE_W'(bus.mem_req_tag), 28'h0000000);
        chk("wr_pf_mrdy", LINE_W'(bus.miss_ready), 0);
        bus.miss_valid = 1'b1; bus.miss_tag = 28'h321;
        tick();
        chk_idle("cx");
        tick();
        chk("cx_reqv", LINE_W'(bus.mem_req_valid), 1);
        chk("cx_reqt", LINE_W'(bus.mem_req_tag), 28'h321);
        bus.miss_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = 28'h321; bus.mem_rsp_line = LINE_A5;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("cx_fillv", LINE_W'(bus.fill_valid), 1);
        chk("cx_fillt", LINE_W'(bus.fill_tag), 28'h321);
        tick();
        chk("cx_pf_reqt", LINE_W'(bus.mem_req_tag), 28'h322);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_idle("cx_end");
`else
        chk_idle("wr_nopf");
        tick();
        chk_idle("wr_nopf2");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
